reg_scoreboard: RTL and testbench
=================================

// Module: reg_scoreboard
// PURPOSE
//   Issue-stage scoreboard that sequences access to the 32x32 MIPS register file. It tracks
//   which architectural registers have a write in flight (issued, not yet written back).
//   It stalls decode on RAW/WAW hazards and on outstanding-write overflow.
//   It sits between decode and the register file's rs/rt read ports and its wr_reg/RegWrite
//   write port.
// PARAMETERS
//   MAX_PEND   3  max outstanding writes in flight (1..24); issue stalls at this count
//   WB_BYPASS  0  1: a register cleared by writeback this cycle is not a RAW hazard (needs forwarding)
//   CNT_W      16 width of stall-cycle performance counter (saturating)
// PORTS
//   clk          in   1      clock, rising edge
//   rst_n        in   1      asynchronous, active-low reset
//   id_valid     in   1      decode presents an instruction
//   id_rs        in   5      source register 1
//   id_rt        in   5      source register 2
//   id_use_rs    in   1      instruction reads rs
//   id_use_rt    in   1      instruction reads rt
//   id_wr_en     in   1      instruction writes a register
//   id_wr_reg    in   5      destination register
//   id_stall     out  1      combinational; 1 = hold decode, instruction not issued
//   wb_valid     in   1      writeback stage asserts RegWrite this cycle
//   wb_reg       in   5      register being written back
//   flush        in   1      pipeline flush; discards all in-flight writes
//   busy         out  32     registered busy vector, bit n = reg n pending
//   pend_cnt     out  5      registered count of set busy bits
//   stall_cnt    out  CNT_W  registered saturating count of cycles with id_valid & id_stall
//   err_spurious out  1      sticky; writeback to a non-busy trackable register
// BEHAVIOUR
//   - Reset (async, rst_n=0): busy=0, pend_cnt=0, stall_cnt=0, err_spurious=0; id_stall=0 follows.
//   - Trackable regs: 0 excluded; only 2..25 implemented in regfile. Reg 0, 1 and 26..31 never set busy.
//   - raw_rs = id_use_rs & busy[id_rs] & ~(WB_BYPASS & wb_valid & wb_reg==id_rs); raw_rt likewise.
//   - waw = id_wr_en & trackable(id_wr_reg) & busy[id_wr_reg] (no bypass for WAW).
//   - full = id_wr_en & trackable(id_wr_reg) & (pend_cnt == MAX_PEND) & ~(wb clears a busy reg this cycle).
//   - id_stall = id_valid & (raw_rs | raw_rt | waw | full); zero-latency combinational.
//   - issue = id_valid & ~id_stall & id_wr_en & trackable(id_wr_reg): set busy[id_wr_reg] next edge.
//   - clr = wb_valid & trackable(wb_reg) & busy[wb_reg]: clear busy[wb_reg] next edge.
//   - wb_valid to trackable non-busy reg: no state change; err_spurious<=1.
//   - wb to untracked reg: ignored, no error.
//   - pend_cnt next = pend_cnt + issue - clr; simultaneous issue+clr leaves count unchanged.
//   - Set and clear of the same reg in one cycle cannot occur (WAW stall).
//   - flush=1: busy<=0, pend_cnt<=0 next edge; overrides same-cycle issue and clr.
//   - id_stall is still computed from current busy during flush cycle.
//   - stall_cnt increments when id_valid & id_stall, saturates at all-ones, never wraps; flush doesn't clear it.
//   - Invariant (assert): pend_cnt == popcount(busy) <= MAX_PEND; busy[0]=busy[1]=0; busy[31:26]=0.
// STRUCTURE
//   - Shared package mips_regs_pkg: REG_W=5, NUM_REGS=32, REG_ZERO=0, REG_AT=1, REG_LAST_IMPL=25,
//     function is_trackable(idx) (2..25); shared with the register file and decode.
//   - One sub-module: sat_counter (parameter W, inc, clr) for stall_cnt; rest flat: busy flops,
//     hazard compare logic, pend_cnt up/down counter.
// TESTING
//   1. Reset mid-run with busy=0x0000_0300 -> busy=0, pend_cnt=0, stall_cnt=0, err_spurious=0
//      immediately, without clock.
//   2. Issue wr t0(8); next cycle busy[8]=1, pend_cnt=1; issue rs=8 -> id_stall=1.
//      Then wb_reg=8 with WB_BYPASS=0 -> id_stall stays 1 that cycle, 0 the next.
//   3. WB_BYPASS=1, busy[8]=1, same cycle wb_reg=8 and id_rs=8 -> id_stall=0.
//      Issue with id_wr_reg=9 while busy[9]=1 -> id_stall=1 (WAW).
//   4. MAX_PEND=3: issue writes to 8,9,10 -> pend_cnt=3.
//      Issue wr 11 -> stall; same with wb_reg=8 -> no stall, pend_cnt stays 3, busy=0x0E00.
//   5. Issue writes to regs 0, 1, 26, 31 -> never stall, busy unchanged, pend_cnt unchanged.
//   6. busy=0x0700 + flush with concurrent issue of 12 -> busy=0, pend_cnt=0.
//      Later wb_reg=9 -> err_spurious=1 sticky; hold stall 2^CNT_W+5 cycles -> stall_cnt=all-ones.

Source files
------------

// File: rtl/mips_regs_pkg.sv
// Register-file geometry shared by decode, the register file and the issue scoreboard.
// Only registers 2..25 are backed by storage and so can have a write in flight.
package mips_regs_pkg;

    localparam int unsigned REG_W    = 5;
    localparam int unsigned NUM_REGS = 32;

    localparam logic [REG_W-1:0] REG_ZERO      = 5'd0;
    localparam logic [REG_W-1:0] REG_AT        = 5'd1;
    localparam logic [REG_W-1:0] REG_LAST_IMPL = 5'd25;

    function automatic logic is_trackable(input logic [REG_W-1:0] idx);
        return (idx > REG_AT) && (idx <= REG_LAST_IMPL);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-stage scoreboard: tracks registers with a write in flight and stalls decode on
// RAW/WAW hazards or when the number of outstanding writes reaches MAX_PEND.
module reg_scoreboard
    import mips_regs_pkg::*;
#(
    parameter int unsigned MAX_PEND  = 3,
    parameter bit          WB_BYPASS = 1'b0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic               id_use_rs,
    input  logic               id_use_rt,
    input  logic               id_wr_en,
    input  logic [REG_W-1:0]   id_wr_reg,
    output logic               id_stall,
    input  logic               wb_valid,
    input  logic [REG_W-1:0]   wb_reg,
    input  logic               flush,
    output logic [NUM_REGS-1:0] busy,
    output logic [4:0]         pend_cnt,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic               err_spurious
);

    localparam logic [4:0] MAX_PEND_C = 5'(MAX_PEND);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_d;
    logic [4:0]          r_pend_cnt;
    logic [4:0]          w_pend_d;
    logic                r_err;

    logic w_wr_track;
    logic w_clr;
    logic w_spurious;
    logic w_raw_rs;
    logic w_raw_rt;
    logic w_waw;
    logic w_full;
    logic w_issue;

    assign w_wr_track = id_wr_en & is_trackable(id_wr_reg);
    assign w_clr      = wb_valid & is_trackable(wb_reg) & r_busy[wb_reg];
    assign w_spurious = wb_valid & is_trackable(wb_reg) & ~r_busy[wb_reg];

    // With forwarding, a source retiring this cycle can be read without waiting.
    assign w_raw_rs = id_use_rs & r_busy[id_rs] & ~(WB_BYPASS & wb_valid & (wb_reg == id_rs));
    assign w_raw_rt = id_use_rt & r_busy[id_rt] & ~(WB_BYPASS & wb_valid & (wb_reg == id_rt));
    assign w_waw    = w_wr_track & r_busy[id_wr_reg];
    assign w_full   = w_wr_track & (r_pend_cnt == MAX_PEND_C) & ~w_clr;

    assign id_stall = id_valid & (w_raw_rs | w_raw_rt | w_waw | w_full);
    assign w_issue  = id_valid & ~id_stall & w_wr_track;

    always_comb begin
        w_busy_d = r_busy;
        w_pend_d = r_pend_cnt;
        if (w_issue) begin
            w_busy_d[id_wr_reg] = 1'b1;
        end
        if (w_clr) begin
            w_busy_d[wb_reg] = 1'b0;
        end
        case ({w_issue, w_clr})
            2'b10:   w_pend_d = r_pend_cnt + 5'd1;
            2'b01:   w_pend_d = r_pend_cnt - 5'd1;
            default: w_pend_d = r_pend_cnt;
        endcase
        if (flush) begin
            w_busy_d = '0;
            w_pend_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_pend_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_busy     <= w_busy_d;
            r_pend_cnt <= w_pend_d;
            if (w_spurious) begin
                r_err <= 1'b1;
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (id_valid & id_stall),
        .clr  (1'b0),
        .cnt  (stall_cnt)
    );

    assign busy         = r_busy;
    assign pend_cnt     = r_pend_cnt;
    assign err_spurious = r_err;

    a_pend_matches_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (r_pend_cnt == 5'($countones(r_busy))) && (r_pend_cnt <= MAX_PEND_C));
    a_untracked_idle: assert property (@(posedge clk) disable iff (!rst_n)
        (r_busy[1:0] == 2'b00) && (r_busy[31:26] == 6'b0));

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: instance a uses defaults, instance b has forwarding
// enabled and a 4-bit stall counter so saturation is reachable quickly.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_use_rs, id_use_rt, id_wr_en;
    logic [4:0]  id_rs, id_rt, id_wr_reg;
    logic        wb_valid, flush;
    logic [4:0]  wb_reg;

    logic        stall_a, err_a, stall_b, err_b;
    logic [31:0] busy_a, busy_b;
    logic [4:0]  pend_a, pend_b;
    logic [15:0] scnt_a;
    logic [3:0]  scnt_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    reg_scoreboard u_dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
        .id_wr_reg(id_wr_reg), .id_stall(stall_a), .wb_valid(wb_valid), .wb_reg(wb_reg),
        .flush(flush), .busy(busy_a), .pend_cnt(pend_a), .stall_cnt(scnt_a),
        .err_spurious(err_a)
    );

    reg_scoreboard #(.MAX_PEND(3), .WB_BYPASS(1'b1), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
        .id_wr_reg(id_wr_reg), .id_stall(stall_b), .wb_valid(wb_valid), .wb_reg(wb_reg),
        .flush(flush), .busy(busy_b), .pend_cnt(pend_b), .stall_cnt(scnt_b),
        .err_spurious(err_b)
    );

    task automatic idle();
        id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_wr_en = 0;
        id_rs = 0; id_rt = 0; id_wr_reg = 0;
        wb_valid = 0; wb_reg = 0; flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        tick();
        rst_n = 1;
        #1;
    endtask

    task automatic drv_wr(input logic [4:0] r);
        idle();
        id_valid = 1; id_wr_en = 1; id_wr_reg = r;
        #1;
    endtask

    task automatic drv_rd(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt);
        idle();
        id_valid = 1; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        drv_wr(5'd8); tick();
        drv_wr(5'd9); tick();
        drv_wr(5'd9); tick();  // WAW stall, counted once
        drv_rd(5'd8, 5'd0, 1'b1, 1'b0);
        n_checks++; if (busy_a !== 32'h0000_0300) $display("FAIL pre_reset_busy: got %h want %h", busy_a, 32'h300); else n_pass++;
        n_checks++; if (scnt_a !== 16'd1) $display("FAIL pre_reset_scnt: got %0d want 1", scnt_a); else n_pass++;
        #2 rst_n = 0;
        #1;
        n_checks++; if (busy_a !== 32'h0) $display("FAIL reset_busy: got %h want 0", busy_a); else n_pass++;
        n_checks++; if (pend_a !== 5'd0) $display("FAIL reset_pend: got %0d want 0", pend_a); else n_pass++;
        n_checks++; if (scnt_a !== 16'd0) $display("FAIL reset_scnt: got %0d want 0", scnt_a); else n_pass++;
        n_checks++; if (err_a !== 1'b0) $display("FAIL reset_err: got %b want 0", err_a); else n_pass++;
        n_checks++; if (stall_a !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_a); else n_pass++;
        rst_n = 1;
    endtask

    task automatic test_raw();
        do_reset();
        drv_wr(5'd8);
        n_checks++; if (stall_a !== 1'b0) $display("FAIL raw_issue_stall: got %b want 0", stall_a); else n_pass++;
        tick();
        n_checks++; if (busy_a !== 32'h100) $display("FAIL raw_busy: got %h want %h", busy_a, 32'h100); else n_pass++;
        n_checks++; if (pend_a !== 5'd1) $display("FAIL raw_pend: got %0d want 1", pend_a); else n_pass++;
        drv_rd(5'd8, 5'd0, 1'b1, 1'b0);
        n_checks++; if (stall_a !== 1'b1) $display("FAIL raw_stall: got %b want 1", stall_a); else n_pass++;
        wb_valid = 1; wb_reg = 5'd8; #1;
        n_checks++; if (stall_a !== 1'b1) $display("FAIL raw_wb_nobypass: got %b want 1", stall_a); else n_pass++;
        tick();
        wb_valid = 0; #1;
        n_checks++; if (stall_a !== 1'b0) $display("FAIL raw_after_wb: got %b want 0", stall_a); else n_pass++;
        n_checks++; if (busy_a !== 32'h0) $display("FAIL raw_busy_clr: got %h want 0", busy_a); else n_pass++;
    endtask

    task automatic test_bypass();
        do_reset();
        drv_wr(5'd8); tick();
        drv_rd(5'd8, 5'd0, 1'b1, 1'b0);
        wb_valid = 1; wb_reg = 5'd8; #1;
        n_checks++; if (stall_b !== 1'b0) $display("FAIL bypass_rs: got %b want 0", stall_b); else n_pass++;
        n_checks++; if (stall_a !== 1'b1) $display("FAIL nobypass_rs: got %b want 1", stall_a); else n_pass++;
        tick();
        drv_wr(5'd9); tick();
        drv_wr(5'd9);
        n_checks++; if (stall_b !== 1'b1) $display("FAIL bypass_waw: got %b want 1", stall_b); else n_pass++;
        wb_valid = 1; wb_reg = 5'd9; #1;
        n_checks++; if (stall_b !== 1'b1) $display("FAIL waw_no_bypass: got %b want 1", stall_b); else n_pass++;
        drv_rd(5'd0, 5'd9, 1'b0, 1'b1);
        n_checks++; if (stall_b !== 1'b1) $display("FAIL bypass_raw_rt: got %b want 1", stall_b); else n_pass++;
    endtask

    task automatic test_full();
        do_reset();
        drv_wr(5'd8); tick();
        drv_wr(5'd9); tick();
        drv_wr(5'd10); tick();
        n_checks++; if (pend_a !== 5'd3) $display("FAIL full_pend: got %0d want 3", pend_a); else n_pass++;
        n_checks++; if (busy_a !== 32'h700) $display("FAIL full_busy: got %h want %h", busy_a, 32'h700); else n_pass++;
        drv_wr(5'd11);
        n_checks++; if (stall_a !== 1'b1) $display("FAIL full_stall: got %b want 1", stall_a); else n_pass++;
        wb_valid = 1; wb_reg = 5'd8; #1;
        n_checks++; if (stall_a !== 1'b0) $display("FAIL full_wb_frees: got %b want 0", stall_a); else n_pass++;
        tick();
        idle(); #1;
        n_checks++; if (pend_a !== 5'd3) $display("FAIL full_pend_swap: got %0d want 3", pend_a); else n_pass++;
        n_checks++; if (busy_a !== 32'hE00) $display("FAIL full_busy_swap: got %h want %h", busy_a, 32'hE00); else n_pass++;
    endtask

    task automatic test_untracked();
        logic [4:0] regs [4];
        regs[0] = 5'd0; regs[1] = 5'd1; regs[2] = 5'd26; regs[3] = 5'd31;
        do_reset();
        drv_wr(5'd8); tick();
        for (int i = 0; i < 4; i++) begin
            drv_wr(regs[i]);
            n_checks++; if (stall_a !== 1'b0) $display("FAIL untracked_stall r%0d: got %b want 0", regs[i], stall_a); else n_pass++;
            tick();
            n_checks++; if (busy_a !== 32'h100 || pend_a !== 5'd1) $display("FAIL untracked_state r%0d: got busy %h pend %0d want busy 100 pend 1", regs[i], busy_a, pend_a); else n_pass++;
        end
        idle(); wb_valid = 1; wb_reg = 5'd1; tick();
        idle(); #1;
        n_checks++; if (err_a !== 1'b0) $display("FAIL untracked_wb_err: got %b want 0", err_a); else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        drv_wr(5'd8); tick();
        drv_wr(5'd9); tick();
        drv_wr(5'd10); tick();
        drv_wr(5'd12);
        flush = 1; #1;
        n_checks++; if (stall_a !== 1'b1) $display("FAIL flush_cycle_stall: got %b want 1", stall_a); else n_pass++;
        tick();
        idle(); #1;
        n_checks++; if (busy_a !== 32'h0) $display("FAIL flush_busy: got %h want 0", busy_a); else n_pass++;
        n_checks++; if (pend_a !== 5'd0) $display("FAIL flush_pend: got %0d want 0", pend_a); else n_pass++;
        n_checks++; if (scnt_a !== 16'd1) $display("FAIL flush_keeps_scnt: got %0d want 1", scnt_a); else n_pass++;
        wb_valid = 1; wb_reg = 5'd9; tick();
        idle(); tick(); tick();
        n_checks++; if (err_a !== 1'b1) $display("FAIL spurious_err: got %b want 1", err_a); else n_pass++;
    endtask

    task automatic test_saturate();
        do_reset();
        drv_wr(5'd8); tick();
        drv_rd(5'd8, 5'd0, 1'b1, 1'b0);
        repeat (14) tick();
        n_checks++; if (scnt_b !== 4'd14) $display("FAIL scnt_count: got %0d want 14", scnt_b); else n_pass++;
        repeat (7) tick();
        n_checks++; if (scnt_b !== 4'hF) $display("FAIL scnt_saturate: got %0d want 15", scnt_b); else n_pass++;
        n_checks++; if (scnt_a !== 16'd21) $display("FAIL scnt_a: got %0d want 21", scnt_a); else n_pass++;
    endtask

    initial begin
        idle();
        rst_n = 0;
        #12;
        rst_n = 1;
        test_reset();
        test_raw();
        test_bypass();
        test_full();
        test_untracked();
        test_flush();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
